// File: rtl/psram_qpi_responder.sv
`default_nettype none
// ============================================================================
// Module   : psram_qpi_responder
// Purpose  : Device-side QSPI/QPI PSRAM responder serving reads/writes from an
//            internal byte array; one bit (SPI) or nibble (QPI) per clk cycle.
// Revision : 1.0  initial release
// ============================================================================
module psram_qpi_responder #(
    parameter int          ADDR_BITS = 16,  // 5..24
    parameter int          READ_WAIT = 6,   // must be at least 1
    parameter logic [63:0] DEVICE_ID = 64'h0D5D_0000_0000_0000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       psram_ce_n,
    input  logic [3:0] psram_sio_i,
    output logic [3:0] psram_sio_o,
    output logic [3:0] psram_sio_oe,
    output logic       quad_mode,
    output logic       cmd_err
);

    localparam int CNT_W = ($clog2(READ_WAIT) > 5) ? $clog2(READ_WAIT) : 5;
    localparam logic [CNT_W-1:0] C_WAIT_LAST = CNT_W'(READ_WAIT - 1);

    localparam logic [7:0] C_OP_RSTEN    = 8'h66;
    localparam logic [7:0] C_OP_RST      = 8'h99;
    localparam logic [7:0] C_OP_QUAD_ON  = 8'h35;
    localparam logic [7:0] C_OP_QUAD_OFF = 8'hF5;
    localparam logic [7:0] C_OP_READ_ID  = 8'h9F;
    localparam logic [7:0] C_OP_READ     = 8'hEB;
    localparam logic [7:0] C_OP_WRITE    = 8'h38;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_CMD    = 3'd1,
        S_ADDR   = 3'd2,
        S_WAIT   = 3'd3,
        S_RDATA  = 3'd4,
        S_WDATA  = 3'd5,
        S_IDOUT  = 3'd6,
        S_IGNORE = 3'd7
    } state_t;

    typedef enum logic [1:0] {
        OP_READ  = 2'd0,
        OP_WRITE = 2'd1,
        OP_ID    = 2'd2
    } op_t;

    state_t               state_q;
    op_t                  op_q;
    logic [CNT_W-1:0]     cnt_q;
    logic [6:0]           cmd_q;
    logic [ADDR_BITS-1:0] addr_q;
    logic [3:0]           hi_q;
    logic                 phase_q;
    logic [5:0]           id_idx_q;
    logic                 rst_en_q;
    logic [3:0]           sio_o_q;
    logic [3:0]           sio_oe_q;
    logic                 quad_q;
    logic                 cmd_err_q;

    logic [7:0]           mem_q [0:(1 << ADDR_BITS) - 1];

    logic [7:0]           cmd_full;
    logic                 cmd_last;
    logic [ADDR_BITS-1:0] addr_full;
    logic                 addr_last;
    logic                 wr_en;

    always_comb begin
        cmd_full  = quad_q ? {cmd_q[3:0], psram_sio_i} : {cmd_q, psram_sio_i[0]};
        cmd_last  = quad_q ? (cnt_q == CNT_W'(1)) : (cnt_q == CNT_W'(7));
        // Only the low ADDR_BITS of the 24-bit address are kept while shifting.
        addr_full = {addr_q[ADDR_BITS-5:0], psram_sio_i};
        addr_last = (op_q == OP_ID) ? (cnt_q == CNT_W'(23)) : (cnt_q == CNT_W'(5));
        wr_en     = !reset && !psram_ce_n && (state_q == S_WDATA) && phase_q;
    end

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem_q[addr_q] <= {hi_q, psram_sio_i};
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= S_IDLE;
            op_q      <= OP_READ;
            cnt_q     <= '0;
            cmd_q     <= '0;
            addr_q    <= '0;
            hi_q      <= '0;
            phase_q   <= 1'b0;
            id_idx_q  <= '0;
            rst_en_q  <= 1'b0;
            sio_o_q   <= '0;
            sio_oe_q  <= '0;
            quad_q    <= 1'b0;
            cmd_err_q <= 1'b0;
        end else begin
            cmd_err_q <= 1'b0;
            if (psram_ce_n) begin
                state_q  <= S_IDLE;
                sio_oe_q <= '0;
            end else begin
                case (state_q)
                    S_IDLE: begin
                        cmd_q   <= cmd_full[6:0];
                        cnt_q   <= CNT_W'(1);
                        state_q <= S_CMD;
                    end
                    S_CMD: begin
                        cmd_q <= cmd_full[6:0];
                        cnt_q <= cnt_q + CNT_W'(1);
                        if (cmd_last) begin
                            cnt_q    <= '0;
                            state_q  <= S_IGNORE;
                            rst_en_q <= 1'b0;
                            case (cmd_full)
                                C_OP_RSTEN:    rst_en_q <= 1'b1;
                                C_OP_RST:      if (rst_en_q) quad_q <= 1'b0;
                                C_OP_QUAD_ON:  if (quad_q) cmd_err_q <= 1'b1; else quad_q <= 1'b1;
                                C_OP_QUAD_OFF: if (quad_q) quad_q <= 1'b0; else cmd_err_q <= 1'b1;
                                C_OP_READ_ID: begin
                                    if (quad_q) begin
                                        cmd_err_q <= 1'b1;
                                    end else begin
                                        op_q    <= OP_ID;
                                        state_q <= S_ADDR;
                                    end
                                end
                                C_OP_READ, C_OP_WRITE: begin
                                    if (quad_q) begin
                                        op_q    <= (cmd_full == C_OP_WRITE) ? OP_WRITE : OP_READ;
                                        state_q <= S_ADDR;
                                    end else begin
                                        cmd_err_q <= 1'b1;
                                    end
                                end
                                default:       cmd_err_q <= 1'b1;
                            endcase
                        end
                    end
                    S_ADDR: begin
                        addr_q <= addr_full;
                        cnt_q  <= cnt_q + CNT_W'(1);
                        if (addr_last) begin
                            cnt_q   <= '0;
                            phase_q <= 1'b0;
                            case (op_q)
                                OP_ID: begin
                                    sio_o_q  <= {2'b00, DEVICE_ID[63], 1'b0};
                                    sio_oe_q <= 4'b0010;
                                    id_idx_q <= 6'd62;
                                    state_q  <= S_IDOUT;
                                end
                                OP_WRITE: state_q <= S_WDATA;
                                default:  state_q <= S_WAIT;
                            endcase
                        end
                    end
                    S_WAIT: begin
                        if (cnt_q == C_WAIT_LAST) begin
                            sio_o_q  <= mem_q[addr_q][7:4];
                            sio_oe_q <= 4'hF;
                            phase_q  <= 1'b1;
                            state_q  <= S_RDATA;
                        end else begin
                            cnt_q <= cnt_q + CNT_W'(1);
                        end
                    end
                    S_RDATA: begin
                        // phase_q set means the high nibble is on the bus now.
                        sio_oe_q <= 4'hF;
                        phase_q  <= !phase_q;
                        if (phase_q) begin
                            sio_o_q <= mem_q[addr_q][3:0];
                            addr_q  <= addr_q + ADDR_BITS'(1);
                        end else begin
                            sio_o_q <= mem_q[addr_q][7:4];
                        end
                    end
                    S_WDATA: begin
                        phase_q <= !phase_q;
                        if (phase_q) begin
                            addr_q <= addr_q + ADDR_BITS'(1);
                        end else begin
                            hi_q <= psram_sio_i;
                        end
                    end
                    S_IDOUT: begin
                        sio_o_q  <= {2'b00, DEVICE_ID[id_idx_q], 1'b0};
                        id_idx_q <= id_idx_q - 6'd1;
                    end
                    default: ;
                endcase
            end
        end
    end

    assign psram_sio_o  = sio_o_q;
    assign psram_sio_oe = sio_oe_q;
    assign quad_mode    = quad_q;
    assign cmd_err      = cmd_err_q;

endmodule
`default_nettype wire

// File: tb/tb_psram_qpi_responder.sv
`default_nettype none
// ============================================================================
// Module   : tb_psram_qpi_responder
// Purpose  : Directed self-checking bench: command table plus write/read/ID
//            and reset sequences with hand-computed expectations.
// Revision : 1.0  initial release
// ============================================================================
module tb_psram_qpi_responder;

    logic       clk = 1'b0;
    logic       reset;
    logic       ce_n;
    logic [3:0] sio_i;
    logic [3:0] sio_o;
    logic [3:0] sio_oe;
    logic       quad;
    logic       err;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    psram_qpi_responder #(
        .ADDR_BITS (16),
        .READ_WAIT (6),
        .DEVICE_ID (64'h0D5D_0000_0000_0000)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .psram_ce_n   (ce_n),
        .psram_sio_i  (sio_i),
        .psram_sio_o  (sio_o),
        .psram_sio_oe (sio_oe),
        .quad_mode    (quad),
        .cmd_err      (err)
    );

    typedef struct packed {
        logic [7:0] op;
        logic       exp_quad;
        logic       exp_err;
    } cmd_vec_t;

    localparam int N_VEC = 14;
    cmd_vec_t vecs [N_VEC];

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, got, exp);
        end
    endtask

    // Drive one bus cycle, then observe the outputs registered at its rising edge.
    task automatic cycle(input logic ce, input logic [3:0] d);
        @(negedge clk);
        ce_n  = ce;
        sio_i = d;
        @(posedge clk);
        #1;
    endtask

    task automatic send_cmd(input logic [7:0] op, input logic q, input logic exp_err);
        if (q) begin
            cycle(1'b0, op[7:4]);
            check("cmd_oe", {60'd0, sio_oe}, 64'd0);
            cycle(1'b0, op[3:0]);
        end else begin
            for (int i = 7; i >= 0; i--) begin
                cycle(1'b0, {3'b000, op[i]});
                if (i != 0) check("cmd_oe", {60'd0, sio_oe}, 64'd0);
            end
        end
        check("cmd_err", {63'd0, err}, {63'd0, exp_err});
    endtask

    task automatic send_addr(input logic [23:0] a, input logic q);
        if (q) begin
            for (int i = 5; i >= 0; i--) begin
                cycle(1'b0, a[4*i +: 4]);
                if (i != 0) check("addr_oe", {60'd0, sio_oe}, 64'd0);
            end
        end else begin
            for (int i = 23; i >= 0; i--) begin
                cycle(1'b0, {3'b000, a[i]});
                if (i != 0) check("addr_oe", {60'd0, sio_oe}, 64'd0);
            end
        end
    endtask

    task automatic qpi_write(input logic [23:0] a, input logic [31:0] data, input int n,
                             input logic odd_nib, input logic [3:0] nib);
        send_cmd(8'h38, 1'b1, 1'b0);
        send_addr(a, 1'b1);
        for (int j = 0; j < n; j++) begin
            cycle(1'b0, data[31-8*j -: 4]);
            cycle(1'b0, data[27-8*j -: 4]);
            check("wr_oe", {60'd0, sio_oe}, 64'd0);
        end
        if (odd_nib) cycle(1'b0, nib);
        cycle(1'b1, 4'h0);
    endtask

    task automatic qpi_read(input logic [23:0] a, input int n, output logic [31:0] data);
        data = '0;
        send_cmd(8'hEB, 1'b1, 1'b0);
        send_addr(a, 1'b1);
        for (int j = 0; j < 6; j++) begin
            check("rd_wait_oe", {60'd0, sio_oe}, 64'd0);
            cycle(1'b0, 4'h0);
        end
        for (int j = 0; j < 2 * n; j++) begin
            check("rd_data_oe", {60'd0, sio_oe}, 64'h0F);
            data = {data[27:0], sio_o};
            if (j != 2 * n - 1) cycle(1'b0, 4'h0);
        end
        cycle(1'b1, 4'h0);
        check("rd_abort_oe", {60'd0, sio_oe}, 64'd0);
    endtask

    initial begin
        #200_000;
        $display("FAIL watchdog: simulation time limit reached, %0d tests run", tests);
        $fatal(1);
    end

    initial begin
        logic        mode;
        logic [63:0] id_bits;
        logic [7:0]  id_rep;
        logic [31:0] rd;

        vecs[0]  = '{op: 8'h66, exp_quad: 1'b0, exp_err: 1'b0};
        vecs[1]  = '{op: 8'h99, exp_quad: 1'b0, exp_err: 1'b0};
        vecs[2]  = '{op: 8'h35, exp_quad: 1'b1, exp_err: 1'b0};
        vecs[3]  = '{op: 8'h99, exp_quad: 1'b1, exp_err: 1'b0};
        vecs[4]  = '{op: 8'h0B, exp_quad: 1'b1, exp_err: 1'b1};
        vecs[5]  = '{op: 8'h66, exp_quad: 1'b1, exp_err: 1'b0};
        vecs[6]  = '{op: 8'h0B, exp_quad: 1'b1, exp_err: 1'b1};
        vecs[7]  = '{op: 8'h99, exp_quad: 1'b1, exp_err: 1'b0};
        vecs[8]  = '{op: 8'h66, exp_quad: 1'b1, exp_err: 1'b0};
        vecs[9]  = '{op: 8'h99, exp_quad: 1'b0, exp_err: 1'b0};
        vecs[10] = '{op: 8'h35, exp_quad: 1'b1, exp_err: 1'b0};
        vecs[11] = '{op: 8'hF5, exp_quad: 1'b0, exp_err: 1'b0};
        vecs[12] = '{op: 8'hEB, exp_quad: 1'b0, exp_err: 1'b1};
        vecs[13] = '{op: 8'hF5, exp_quad: 1'b0, exp_err: 1'b1};

        reset = 1'b1;
        ce_n  = 1'b1;
        sio_i = 4'h0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_sio_o", {60'd0, sio_o}, 64'd0);
        check("rst_oe", {60'd0, sio_oe}, 64'd0);
        check("rst_quad", {63'd0, quad}, 64'd0);
        check("rst_err", {63'd0, err}, 64'd0);
        @(negedge clk);
        reset = 1'b0;
        cycle(1'b1, 4'h0);

        // Command table: each row sent in the mode left by the previous row.
        mode = 1'b0;
        for (int v = 0; v < N_VEC; v++) begin
            send_cmd(vecs[v].op, mode, vecs[v].exp_err);
            check("cmd_quad", {63'd0, quad}, {63'd0, vecs[v].exp_quad});
            cycle(1'b0, 4'hF);
            check("err_width", {63'd0, err}, 64'd0);
            check("ignore_oe", {60'd0, sio_oe}, 64'd0);
            cycle(1'b0, 4'hF);
            check("ignore_oe", {60'd0, sio_oe}, 64'd0);
            cycle(1'b1, 4'h0);
            mode = vecs[v].exp_quad;
        end

        // Read-ID: 64 bits, then the stream repeats from the top.
        send_cmd(8'h9F, 1'b0, 1'b0);
        send_addr(24'hA5C3_96, 1'b0);
        id_bits = '0;
        for (int j = 0; j < 64; j++) begin
            if (j < 3) check("id_oe", {60'd0, sio_oe}, 64'h2);
            id_bits = {id_bits[62:0], sio_o[1]};
            cycle(1'b0, 4'h0);
        end
        check("id_stream", id_bits, 64'h0D5D_0000_0000_0000);
        id_rep = '0;
        for (int j = 0; j < 8; j++) begin
            id_rep = {id_rep[6:0], sio_o[1]};
            cycle(1'b0, 4'h0);
        end
        check("id_repeat", {56'd0, id_rep}, 64'h0D);
        cycle(1'b1, 4'h0);
        check("id_abort_oe", {60'd0, sio_oe}, 64'd0);

        send_cmd(8'h35, 1'b0, 1'b0);
        cycle(1'b1, 4'h0);
        check("quad_on", {63'd0, quad}, 64'd1);

        // Write two bytes, read them back.
        qpi_write(24'h000010, 32'hA53C_0000, 2, 1'b0, 4'h0);
        qpi_read(24'h000010, 2, rd);
        check("rd_basic", {32'd0, rd}, 64'hA53C);

        // Burst wraps from the top of the array to address 0.
        qpi_write(24'h000000, 32'hC300_0000, 1, 1'b0, 4'h0);
        qpi_write(24'hFFFFFF, 32'h7E00_0000, 1, 1'b0, 4'h0);
        qpi_read(24'hFFFFFF, 2, rd);
        check("rd_wrap", {32'd0, rd}, 64'h7EC3);

        // Odd trailing nibble is discarded.
        qpi_write(24'h000020, 32'h0066_0000, 2, 1'b0, 4'h0);
        qpi_write(24'h000020, 32'h1200_0000, 1, 1'b1, 4'h4);
        qpi_read(24'h000020, 2, rd);
        check("rd_odd_nib", {32'd0, rd}, 64'h1266);

        // Reset during a read.
        send_cmd(8'hEB, 1'b1, 1'b0);
        send_addr(24'h000010, 1'b1);
        repeat (6) cycle(1'b0, 4'h0);
        check("pre_rst_oe", {60'd0, sio_oe}, 64'h0F);
        check("pre_rst_nib", {60'd0, sio_o}, 64'hA);
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        #1;
        check("rst_rd_oe", {60'd0, sio_oe}, 64'd0);
        check("rst_rd_quad", {63'd0, quad}, 64'd0);
        @(negedge clk);
        reset = 1'b0;
        cycle(1'b1, 4'h0);

        // Reset while the low nibble is on the bus: the byte must not land.
        send_cmd(8'h35, 1'b0, 1'b0);
        cycle(1'b1, 4'h0);
        send_cmd(8'h38, 1'b1, 1'b0);
        send_addr(24'h000010, 1'b1);
        cycle(1'b0, 4'h9);
        @(negedge clk);
        reset = 1'b1;
        sio_i = 4'h6;
        @(posedge clk);
        #1;
        check("rst_wr_oe", {60'd0, sio_oe}, 64'd0);
        @(negedge clk);
        reset = 1'b0;
        cycle(1'b1, 4'h0);
        send_cmd(8'h35, 1'b0, 1'b0);
        cycle(1'b1, 4'h0);
        qpi_read(24'h000010, 1, rd);
        check("rst_wr_nowrite", {32'd0, rd}, 64'hA5);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
`default_nettype wire
